// File: rtl/alpha_pkg.sv
// Shared types for the alpha integer writeback path: the zero-register index
// and the request record carried from the load return port to the register file.
package alpha_pkg;

    localparam logic [4:0] REG_ZERO = 5'd31;

    typedef struct packed {
        logic [4:0]  rc;
        logic [63:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue for load returns that could not be written directly.
// Exposes per-entry valid/rc vectors so the owner can build a pending-register mask.
module wb_fifo
    import alpha_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_req_t
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_push,
    input  T                          i_din,
    input  logic                      i_pop,
    output T                          o_dout,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [DEPTH-1:0]          o_entry_valid,
    output logic [DEPTH-1:0][4:0]     o_entry_rc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointers and per-entry valid bits carry the queue state; reset empties it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + AW'(1);
            end
            if (w_do_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout        = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_entry_valid = r_valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_rc[i] = r_mem[i].rc;
        end
    end

endmodule

// File: rtl/wb_merge.sv
// Writeback merge: ALU results win the register file port, load returns queue behind them.
// Define WB_MERGE_BYPASS_EN to let a lone load skip the queue and write after one cycle.
module wb_merge
    import alpha_pkg::*;
#(
    parameter int LQ_DEPTH = 4,
    parameter int DATA_W   = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alu_valid,
    input  logic [4:0]        i_alu_rc,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [4:0]        i_ld_rc,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_wr_en,
    output logic [4:0]        o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [31:0]       o_lq_pend
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;

    logic                    w_alu_eff;
    logic                    w_ld_accept;
    logic                    w_ld_live;
    logic                    w_bypass;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;
    wb_req_t                 w_push_req;
    wb_req_t                 w_head;
    logic [LQ_DEPTH-1:0]     w_entry_valid;
    logic [LQ_DEPTH-1:0][4:0] w_entry_rc;

    logic                    w_sel_en;
    logic [4:0]              w_sel_rc;
    logic [DATA_W-1:0]       w_sel_data;
    logic [31:0]             w_lq_pend;

    logic                    r_wr_en;
    logic [4:0]              r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;

    // Writes to r31 are architecturally discarded, so they never claim the port or the queue.
    assign w_alu_eff   = i_alu_valid && (i_alu_rc != REG_ZERO);
    assign w_ld_accept = i_ld_valid && o_ld_ready;
    assign w_ld_live   = w_ld_accept && (i_ld_rc != REG_ZERO);

    assign o_ld_ready  = ~w_full;
    assign w_pop       = ~w_alu_eff & ~w_empty;

`ifdef WB_MERGE_BYPASS_EN
    assign w_bypass = w_ld_live & ~w_alu_eff & w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = w_ld_live & ~w_bypass;
    assign w_push_req = '{rc: i_ld_rc, data: i_ld_data};

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .T     (wb_req_t)
    ) u_lq (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_push        (w_push),
        .i_din         (w_push_req),
        .i_pop         (w_pop),
        .o_dout        (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (w_count),
        .o_entry_valid (w_entry_valid),
        .o_entry_rc    (w_entry_rc)
    );

    // Port priority: ALU, then oldest queued load, then a bypassed fresh load.
    always_comb begin
        w_sel_en   = 1'b0;
        w_sel_rc   = '0;
        w_sel_data = '0;
        if (w_alu_eff) begin
            w_sel_en   = 1'b1;
            w_sel_rc   = i_alu_rc;
            w_sel_data = i_alu_data;
        end else if (w_pop) begin
            w_sel_en   = 1'b1;
            w_sel_rc   = w_head.rc;
            w_sel_data = w_head.data;
        end else if (w_bypass) begin
            w_sel_en   = 1'b1;
            w_sel_rc   = i_ld_rc;
            w_sel_data = i_ld_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_sel_en;
            if (w_sel_en) begin
                r_wr_addr <= w_sel_rc;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

    // Mask comes purely from queue entry flops, so a popped entry drops out with its write.
    always_comb begin
        w_lq_pend = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_lq_pend[w_entry_rc[i]] = 1'b1;
            end
        end
    end

    assign o_lq_pend = w_lq_pend;

`ifndef SYNTHESIS
    a_alu_not_pending: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_alu_eff && o_lq_pend[i_alu_rc]));

    a_count_bounded: assert property (@(posedge i_clk) disable iff (i_reset)
        w_count <= CW'(LQ_DEPTH));
`endif

endmodule
